// File: rtl/wb_conbus_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_conbus_rr_if
//  Description : Bundle of the Wishbone master-side and slave-side signals of
//                the shared-bus interconnect wb_conbus_rr.
//                modport slave  : the interconnect itself. It serves the
//                                 masters' requests and drives the slaves.
//                modport master : the environment around the interconnect.
//                                 This covers the masters issuing cycles and
//                                 the slave devices returning data and ACK.
//  Signals     : m_*_i  master request (NM lanes), m_*_o shared/ per-master
//                responses; s_*_o broadcast request, s_*_i per-slave response
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_conbus_rr_if #(
   parameter int NM = 2,
   parameter int NS = 6
);
   // master side
   logic [NM*32-1:0] m_dat_i;
   logic [NM*32-1:0] m_adr_i;
   logic [NM*3-1:0]  m_cti_i;
   logic [NM*4-1:0]  m_sel_i;
   logic [NM-1:0]    m_we_i;
   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [31:0]      m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   // slave side
   logic [31:0]      s_dat_o;
   logic [31:0]      s_adr_o;
   logic [2:0]       s_cti_o;
   logic [3:0]       s_sel_o;
   logic             s_we_o;
   logic             s_stb_o;
   logic [NS-1:0]    s_cyc_o;
   logic [NS*32-1:0] s_dat_i;
   logic [NS-1:0]    s_ack_i;

   modport slave (
      input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o
   );

   modport master (
      output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_conbus_rr.sv
`default_nettype none
// ============================================================================
//  Module      : wb_conbus_rr
//  Description : Wishbone shared-bus interconnect, NM masters to NS slaves.
//                Registered round-robin arbiter with bus hold while the
//                owner keeps CYC high, per-slave decode on adr[31:32-ADDR_W],
//                ERR generation for unmapped addresses and slave timeouts.
//  Ports       : sys_clk  system clock
//                sys_rst  synchronous active-high reset
//                bus      wb_conbus_rr_if.slave (all master/slave signals)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_conbus_rr #(
   parameter int                   NM      = 2,
   parameter int                   NS      = 6,
   parameter int                   ADDR_W  = 3,
   parameter logic [NS*ADDR_W-1:0] S_ADDR  = {3'h6, 3'h5, 3'h4, 3'h3, 3'h2, 3'h0},
   parameter int                   TIMEOUT = 256
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   wb_conbus_rr_if.slave bus
);

   localparam int              PTR_W   = (NM > 1) ? $clog2(NM) : 1;
   localparam int              SEL_W   = (NS > 1) ? $clog2(NS) : 1;
   localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic            WD_EN   = (TIMEOUT > 0);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [NM-1:0]    gnt_q,       gnt_d;        // one-hot owner, 0 = idle
   logic [PTR_W-1:0] rr_ptr_q,    rr_ptr_d;     // round-robin scan start
   logic [WD_W-1:0]  wd_cnt_q,    wd_cnt_d;     // cycles waiting on ACK
   logic             err_q,       err_d;        // one-cycle ERR pulse
   logic             unmap_arm_q, unmap_arm_d;  // unmapped ERR may fire

   // ------------------------------------------------------------------------
   // Granted-master mux; everything reads 0 while the bus is idle
   // ------------------------------------------------------------------------
   logic [PTR_W-1:0] owner;
   logic             bus_cyc;
   logic             bus_stb;
   logic             bus_we;
   logic [31:0]      bus_adr;
   logic [31:0]      bus_dat;
   logic [2:0]       bus_cti;
   logic [3:0]       bus_sel;

   always_comb begin
      owner   = '0;
      bus_cyc = 1'b0;
      bus_stb = 1'b0;
      bus_we  = 1'b0;
      bus_adr = '0;
      bus_dat = '0;
      bus_cti = '0;
      bus_sel = '0;
      for (int j = 0; j < NM; j++) begin
         if (gnt_q[j]) begin
            owner   = PTR_W'(j);
            bus_cyc = bus.m_cyc_i[j];
            bus_stb = bus.m_stb_i[j];
            bus_we  = bus.m_we_i[j];
            bus_adr = bus.m_adr_i[j*32 +: 32];
            bus_dat = bus.m_dat_i[j*32 +: 32];
            bus_cti = bus.m_cti_i[j*3 +: 3];
            bus_sel = bus.m_sel_i[j*4 +: 4];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Address decode; scanning downwards lets the lowest index win overlaps
   // ------------------------------------------------------------------------
   logic             hit;
   logic [SEL_W-1:0] sel;

   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int k = NS - 1; k >= 0; k--) begin
         if (bus_adr[31 -: ADDR_W] == S_ADDR[k*ADDR_W +: ADDR_W]) begin
            hit = 1'b1;
            sel = SEL_W'(k);
         end
      end
   end

   logic bus_req;     // granted master has CYC and STB up
   logic match;       // bus cycle towards a mapped slave
   logic slave_ack;   // ACK of the addressed slave only
   logic unmapped;

   assign bus_req   = bus_cyc & bus_stb;
   assign match     = bus_cyc & hit;
   assign slave_ack = match & bus.s_ack_i[sel];
   assign unmapped  = bus_req & ~hit;

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.s_dat_o = bus_dat;
   assign bus.s_adr_o = bus_adr;
   assign bus.s_cti_o = bus_cti;
   assign bus.s_sel_o = bus_sel;
   assign bus.s_we_o  = bus_we;
   assign bus.s_stb_o = bus_stb;
   // CYC drops during the ERR cycle so a hung slave sees its cycle aborted
   assign bus.s_cyc_o = (match & ~err_q) ? (NS'(1) << sel) : '0;
   assign bus.m_dat_o = match ? bus.s_dat_i[sel*32 +: 32] : 32'h0;
   assign bus.m_ack_o = slave_ack ? gnt_q : '0;
   // A late ACK landing on the ERR cycle completes the transfer normally
   assign bus.m_err_o = (err_q & ~slave_ack) ? gnt_q : '0;

   // ------------------------------------------------------------------------
   // Round-robin arbiter
   // ------------------------------------------------------------------------
   function automatic logic [NM-1:0] rr_pick(input logic [NM-1:0]    req,
                                             input logic [PTR_W-1:0] start);
      logic [NM-1:0] onehot;
      logic          found;
      int            idx;
      onehot = '0;
      found  = 1'b0;
      for (int i = 0; i < NM; i++) begin
         idx = (int'(start) + i) % NM;
         if (!found && req[idx]) begin
            onehot[idx] = 1'b1;
            found       = 1'b1;
         end
      end
      return onehot;
   endfunction

   logic [PTR_W-1:0] ptr_after_owner;
   assign ptr_after_owner = (owner == PTR_W'(NM - 1)) ? '0 : owner + 1'b1;

   always_comb begin
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
      if (gnt_q == '0) begin
         gnt_d = rr_pick(bus.m_cyc_i, rr_ptr_q);
      end else if (!bus_cyc) begin
         // Owner released the bus: it goes to the back of the queue
         rr_ptr_d = ptr_after_owner;
         gnt_d    = rr_pick(bus.m_cyc_i, ptr_after_owner);
      end
   end

   // ------------------------------------------------------------------------
   // Watchdog and ERR generation
   // ------------------------------------------------------------------------
   logic grant_chg;
   logic wd_run;
   logic wd_fire;

   assign grant_chg = (gnt_d != gnt_q);
   assign wd_run    = WD_EN & match & bus_stb & ~slave_ack;
   assign wd_fire   = wd_run & (wd_cnt_q == WD_LAST);

   always_comb begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (grant_chg || !wd_run || wd_fire) begin
         wd_cnt_d = '0;
      end

      err_d = (unmapped & unmap_arm_q) | wd_fire;

      // One unmapped ERR per strobe: a new one needs STB to be seen low
      unmap_arm_d = unmap_arm_q;
      if (!bus_req) begin
         unmap_arm_d = 1'b1;
      end else if (unmapped) begin
         unmap_arm_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         gnt_q       <= '0;
         rr_ptr_q    <= '0;
         wd_cnt_q    <= '0;
         err_q       <= 1'b0;
         unmap_arm_q <= 1'b1;
      end else begin
         gnt_q       <= gnt_d;
         rr_ptr_q    <= rr_ptr_d;
         wd_cnt_q    <= wd_cnt_d;
         err_q       <= err_d;
         unmap_arm_q <= unmap_arm_d;
      end
   end

endmodule
`default_nettype wire
